// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper
//   Player-input front end for arcade cores. Decodes ps2_key toggle events into per-player key
//   state, ORs it with the hps_io joysticks, resolves opposing directions, stretches coins to a
//   fixed pulse and optionally swaps coin/start. All outputs are registered and active-low.
//
// Ports
//   clk_sys  : system clock
//   reset    : asynchronous, active-high reset
//   ps2_key  : {toggle, pressed, ext, scancode[7:0]}
//   joy      : 16 bits per player, [0] right [1] left [2] down [3] up [4] coin [5] start
//   swap_cs  : 1 = coin signal drives start_n, start signal drives coin_n
//   dir_n    : per player {up, down, left, right}, active-low
//   coin_n   : per player stretched coin, active-low
//   start_n  : per player start, active-low
module arcade_input_mapper #(
  parameter int unsigned PLAYERS      = 2,
  parameter int unsigned COIN_PULSE   = 120000,
  parameter bit          SOCD_NEUTRAL = 1'b1
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [10:0]           ps2_key,
  input  logic [16*PLAYERS-1:0] joy,
  input  logic                  swap_cs,
  output logic [4*PLAYERS-1:0]  dir_n,
  output logic [PLAYERS-1:0]    coin_n,
  output logic [PLAYERS-1:0]    start_n
);

  localparam int unsigned     CntW    = $clog2(COIN_PULSE + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(COIN_PULSE);

  // Bit positions shared by key state and joystick words.
  localparam int unsigned BitRight = 0;
  localparam int unsigned BitLeft  = 1;
  localparam int unsigned BitDown  = 2;
  localparam int unsigned BitUp    = 3;
  localparam int unsigned BitCoin  = 4;
  localparam int unsigned BitStart = 5;

  function automatic logic [7:0] start_code(input int unsigned p);
    case (p)
      0:       return 8'h16;
      1:       return 8'h1E;
      2:       return 8'h26;
      default: return 8'h25;
    endcase
  endfunction

  function automatic logic [7:0] coin_code(input int unsigned p);
    case (p)
      0:       return 8'h2E;
      1:       return 8'h36;
      2:       return 8'h3D;
      default: return 8'h3E;
    endcase
  endfunction

  logic                           toggle_q;
  logic                           primed_q;
  logic [PLAYERS-1:0][5:0]        key_q, key_d;
  logic [PLAYERS-1:0]             prev_coin_q, prev_coin_d;
  logic [PLAYERS-1:0][CntW-1:0]   cnt_q, cnt_d;
  logic [4*PLAYERS-1:0]           dir_n_d;
  logic [PLAYERS-1:0]             coin_n_d, start_n_d;

  logic       key_event;
  logic       key_pressed;
  logic       key_ext;
  logic [7:0] key_code;

  assign key_pressed = ps2_key[9];
  assign key_ext     = ps2_key[8];
  assign key_code    = ps2_key[7:0];
  // The first clock after reset only captures the toggle, so a high toggle at reset is no event.
  assign key_event   = primed_q && (ps2_key[10] != toggle_q);

  always_comb begin
    key_d = key_q;
    if (key_event) begin
      for (int unsigned p = 0; p < PLAYERS; p++) begin
        // Arrow keys ignore the extended prefix.
        if (p == 0) begin
          case (key_code)
            8'h75:   key_d[p][BitUp]    = key_pressed;
            8'h72:   key_d[p][BitDown]  = key_pressed;
            8'h6B:   key_d[p][BitLeft]  = key_pressed;
            8'h74:   key_d[p][BitRight] = key_pressed;
            default: ;
          endcase
        end
        if (!key_ext) begin
          if (p == 1) begin
            case (key_code)
              8'h2D:   key_d[p][BitUp]    = key_pressed;
              8'h2B:   key_d[p][BitDown]  = key_pressed;
              8'h23:   key_d[p][BitLeft]  = key_pressed;
              8'h34:   key_d[p][BitRight] = key_pressed;
              default: ;
            endcase
          end
          if (key_code == start_code(p)) key_d[p][BitStart] = key_pressed;
          if (key_code == coin_code(p))  key_d[p][BitCoin]  = key_pressed;
        end
      end
    end
  end

  always_comb begin
    logic [5:0] raw;
    logic       up, down, left, right, coin_act;
    raw         = '0;
    up          = 1'b0;
    down        = 1'b0;
    left        = 1'b0;
    right       = 1'b0;
    coin_act    = 1'b0;
    cnt_d       = cnt_q;
    prev_coin_d = prev_coin_q;
    dir_n_d     = '1;
    coin_n_d    = '1;
    start_n_d   = '1;
    for (int unsigned p = 0; p < PLAYERS; p++) begin
      raw   = key_q[p] | joy[16*p +: 6];
      up    = raw[BitUp];
      down  = raw[BitDown];
      left  = raw[BitLeft];
      right = raw[BitRight];
      if (SOCD_NEUTRAL && left && right) begin
        left  = 1'b0;
        right = 1'b0;
      end
      if (SOCD_NEUTRAL && up && down) begin
        up   = 1'b0;
        down = 1'b0;
      end
      dir_n_d[4*p +: 4] = ~{up, down, left, right};

      // Edges arriving mid-pulse are dropped; prev_coin reloads unconditionally so a coin held
      // through reset needs a release before it can fire again.
      if (cnt_q[p] != '0) begin
        cnt_d[p] = cnt_q[p] - 1'b1;
      end else if (primed_q && raw[BitCoin] && !prev_coin_q[p]) begin
        cnt_d[p] = CntLoad;
      end
      prev_coin_d[p] = raw[BitCoin];
      coin_act       = (cnt_d[p] != '0);

      coin_n_d[p]  = ~(swap_cs ? raw[BitStart] : coin_act);
      start_n_d[p] = ~(swap_cs ? coin_act : raw[BitStart]);
    end
  end

  // Joystick bits 15:6 carry nothing this block uses.
  logic unused_joy;
  always_comb begin
    unused_joy = 1'b0;
    for (int unsigned p = 0; p < PLAYERS; p++) unused_joy ^= ^joy[16*p+6 +: 10];
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      toggle_q    <= 1'b0;
      primed_q    <= 1'b0;
      key_q       <= '0;
      prev_coin_q <= '0;
      cnt_q       <= '0;
      dir_n       <= '1;
      coin_n      <= '1;
      start_n     <= '1;
    end else begin
      toggle_q    <= ps2_key[10];
      primed_q    <= 1'b1;
      key_q       <= key_d;
      prev_coin_q <= prev_coin_d;
      cnt_q       <= cnt_d;
      dir_n       <= dir_n_d;
      coin_n      <= coin_n_d;
      start_n     <= start_n_d;
    end
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: two instances (2 players / pulse 8 / SOCD neutral and
// 4 players / pulse 5 / SOCD pass-through), directed scenarios plus random traffic checked
// against a table-driven reference model.
module tb_arcade_input_mapper;

  localparam int unsigned PA = 2;
  localparam int unsigned PulseA = 8;
  localparam int unsigned PB = 4;
  localparam int unsigned PulseB = 5;

  logic clk = 1'b0;
  logic rst;
  logic [10:0] ps2_key;
  logic [16*PA-1:0] joy_a;
  logic [16*PB-1:0] joy_b;
  logic swap;
  logic [4*PA-1:0] dir_a;
  logic [PA-1:0] coin_a, start_a;
  logic [4*PB-1:0] dir_b;
  logic [PB-1:0] coin_b, start_b;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  arcade_input_mapper #(.PLAYERS(PA), .COIN_PULSE(PulseA), .SOCD_NEUTRAL(1'b1)) dut_a (
    .clk_sys(clk), .reset(rst), .ps2_key(ps2_key), .joy(joy_a), .swap_cs(swap),
    .dir_n(dir_a), .coin_n(coin_a), .start_n(start_a)
  );

  arcade_input_mapper #(.PLAYERS(PB), .COIN_PULSE(PulseB), .SOCD_NEUTRAL(1'b0)) dut_b (
    .clk_sys(clk), .reset(rst), .ps2_key(ps2_key), .joy(joy_b), .swap_cs(swap),
    .dir_n(dir_b), .coin_n(coin_b), .start_n(start_b)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] code;
    bit         arrow;
    int         player;
    int         bitn;
  } map_t;
  map_t keymap[20];

  bit   m_primed, m_tog;
  bit   m_key[2][4][6];
  bit   m_prev[2][4];
  int   m_end[2][4];   // first edge after which the pulse is over
  int   cyc = 0;
  logic [15:0] e_dir[2];
  logic [3:0]  e_coin[2], e_start[2];

  initial begin
    keymap[0]  = '{8'h75, 1'b1, 0, 3};
    keymap[1]  = '{8'h72, 1'b1, 0, 2};
    keymap[2]  = '{8'h6B, 1'b1, 0, 1};
    keymap[3]  = '{8'h74, 1'b1, 0, 0};
    keymap[4]  = '{8'h2D, 1'b0, 1, 3};
    keymap[5]  = '{8'h2B, 1'b0, 1, 2};
    keymap[6]  = '{8'h23, 1'b0, 1, 1};
    keymap[7]  = '{8'h34, 1'b0, 1, 0};
    keymap[8]  = '{8'h16, 1'b0, 0, 5};
    keymap[9]  = '{8'h1E, 1'b0, 1, 5};
    keymap[10] = '{8'h26, 1'b0, 2, 5};
    keymap[11] = '{8'h25, 1'b0, 3, 5};
    keymap[12] = '{8'h2E, 1'b0, 0, 4};
    keymap[13] = '{8'h36, 1'b0, 1, 4};
    keymap[14] = '{8'h3D, 1'b0, 2, 4};
    keymap[15] = '{8'h3E, 1'b0, 3, 4};
    keymap[16] = '{8'h16, 1'b0, 0, 5};
    keymap[17] = '{8'h2E, 1'b0, 0, 4};
    keymap[18] = '{8'h75, 1'b1, 0, 3};
    keymap[19] = '{8'h74, 1'b1, 0, 0};
  end

  task automatic model_edge();
    bit ev, u, d, l, r, act, socd;
    bit [5:0] raw;
    int np, pulse;
    cyc++;
    if (rst) begin
      m_primed = 1'b0;
      m_tog = 1'b0;
      for (int i = 0; i < 2; i++) begin
        for (int p = 0; p < 4; p++) begin
          for (int b = 0; b < 6; b++) m_key[i][p][b] = 1'b0;
          m_prev[i][p] = 1'b0;
          m_end[i][p] = cyc;
        end
        e_dir[i] = '1;
        e_coin[i] = '1;
        e_start[i] = '1;
      end
    end else begin
      ev = m_primed && (ps2_key[10] != m_tog);
      for (int i = 0; i < 2; i++) begin
        np = (i == 0) ? PA : PB;
        pulse = (i == 0) ? PulseA : PulseB;
        socd = (i == 0);
        for (int p = 0; p < np; p++) begin
          for (int b = 0; b < 6; b++)
            raw[b] = m_key[i][p][b] | ((i == 0) ? joy_a[16*p+b] : joy_b[16*p+b]);
          r = raw[0]; l = raw[1]; d = raw[2]; u = raw[3];
          if (socd && l && r) begin l = 0; r = 0; end
          if (socd && u && d) begin u = 0; d = 0; end
          e_dir[i][4*p +: 4] = ~{u, d, l, r};
          if (m_primed && raw[4] && !m_prev[i][p] && cyc > m_end[i][p]) m_end[i][p] = cyc + pulse;
          m_prev[i][p] = raw[4];
          act = (cyc < m_end[i][p]);
          e_coin[i][p] = ~(swap ? raw[5] : act);
          e_start[i][p] = ~(swap ? act : raw[5]);
        end
      end
      if (ev) begin
        for (int k = 0; k < 20; k++) begin
          if (keymap[k].code == ps2_key[7:0] && (keymap[k].arrow || !ps2_key[8])) begin
            for (int i = 0; i < 2; i++) begin
              np = (i == 0) ? PA : PB;
              if (keymap[k].player < np) m_key[i][keymap[k].player][keymap[k].bitn] = ps2_key[9];
            end
          end
        end
      end
      m_tog = ps2_key[10];
      m_primed = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send_key(input bit pressed, input bit ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; swap = 1'b0; joy_a = '0; joy_b = '0;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h6B};
    #1;
    n_checks++;
    if ({dir_a, coin_a, start_a, dir_b, coin_b, start_b} !== '1) begin
      n_fail++;
      $display("FAIL reset_async: a=%b/%b/%b b=%b/%b/%b expected all ones",
               dir_a, coin_a, start_a, dir_b, coin_b, start_b);
    end
    repeat (3) tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_checks++;
      if ({dir_a, coin_a, start_a, dir_b, coin_b, start_b} !== '1) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: a=%b/%b/%b b=%b/%b/%b expected all ones",
                 k, dir_a, coin_a, start_a, dir_b, coin_b, start_b);
      end
    end
  endtask

  task automatic test_arrow_ext();
    send_key(1'b1, 1'b1, 8'h6B);
    tick();
    n_checks++;
    if (dir_a[1] !== 1'b1) begin
      n_fail++; $display("FAIL arrow_latency: dir_a[1]=%b expected 1 one edge after event", dir_a[1]);
    end
    tick();
    n_checks++;
    if (dir_a[1] !== 1'b0 || dir_b[1] !== 1'b0) begin
      n_fail++; $display("FAIL arrow_press: dir_a[1]=%b dir_b[1]=%b expected 0", dir_a[1], dir_b[1]);
    end
    send_key(1'b0, 1'b1, 8'h6B);
    tick(); tick();
    n_checks++;
    if (dir_a[1] !== 1'b1) begin
      n_fail++; $display("FAIL arrow_release: dir_a[1]=%b expected 1", dir_a[1]);
    end
    send_key(1'b1, 1'b1, 8'h16);  // start code with ext set is not a start
    tick(); tick();
    n_checks++;
    if (start_a[0] !== 1'b1) begin
      n_fail++; $display("FAIL ext_start_ignored: start_a[0]=%b expected 1", start_a[0]);
    end
  endtask

  task automatic test_socd();
    joy_a[1:0] = 2'b11; joy_b[1:0] = 2'b11;
    tick();
    n_checks++;
    if (dir_a[1:0] !== 2'b11 || dir_b[1:0] !== 2'b00) begin
      n_fail++;
      $display("FAIL socd_lr: dir_a[1:0]=%b expected 11, dir_b[1:0]=%b expected 00",
               dir_a[1:0], dir_b[1:0]);
    end
    joy_a[0] = 1'b0;
    tick();
    n_checks++;
    if (dir_a[1:0] !== 2'b01) begin
      n_fail++; $display("FAIL socd_left_only: dir_a[1:0]=%b expected 01", dir_a[1:0]);
    end
    joy_a[3:0] = 4'b1100; joy_b[3:0] = 4'b0000;
    tick();
    n_checks++;
    if (dir_a[3:0] !== 4'b1111) begin
      n_fail++; $display("FAIL socd_ud: dir_a[3:0]=%b expected 1111", dir_a[3:0]);
    end
    joy_a[3:0] = 4'b0000;
    tick();
  endtask

  task automatic test_coin_no_retrigger();
    for (int k = 0; k < 20; k++) begin
      joy_a[20] = (k < 3) || (k >= 5 && k < 8);
      tick();
      n_checks++;
      if (coin_a[1] !== ((k < PulseA) ? 1'b0 : 1'b1) || coin_a[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL coin_pulse1 cycle %0d: coin_a=%b expected bit1=%b bit0=1",
                 k, coin_a, (k < PulseA) ? 1'b0 : 1'b1);
      end
    end
    for (int k = 0; k < 15; k++) begin
      joy_a[20] = (k < 12);
      tick();
      n_checks++;
      if (coin_a[1] !== ((k < PulseA) ? 1'b0 : 1'b1)) begin
        n_fail++;
        $display("FAIL coin_pulse2 cycle %0d: coin_a[1]=%b expected %b",
                 k, coin_a[1], (k < PulseA) ? 1'b0 : 1'b1);
      end
    end
  endtask

  task automatic test_swap();
    swap = 1'b1;
    send_key(1'b1, 1'b0, 8'h16);
    tick();
    n_checks++;
    if (coin_a[0] !== 1'b1) begin
      n_fail++; $display("FAIL swap_latency: coin_a[0]=%b expected 1", coin_a[0]);
    end
    tick();
    n_checks++;
    if (coin_a[0] !== 1'b0 || start_a[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL swap_start: coin_a[0]=%b expected 0, start_a[0]=%b expected 1",
               coin_a[0], start_a[0]);
    end
    swap = 1'b0;
    tick();
    n_checks++;
    if (coin_a[0] !== 1'b1 || start_a[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL unswap: coin_a[0]=%b expected 1, start_a[0]=%b expected 0",
               coin_a[0], start_a[0]);
    end
    swap = 1'b1;
    send_key(1'b0, 1'b0, 8'h16);
    tick(); tick();
    n_checks++;
    if (coin_a[0] !== 1'b1 || start_a[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL swap_release: coin_a[0]=%b start_a[0]=%b expected 1 1", coin_a[0], start_a[0]);
    end
    swap = 1'b0;
    tick();
  endtask

  task automatic test_player_range();
    send_key(1'b1, 1'b0, 8'h26);
    tick(); tick();
    n_checks++;
    if (start_b[2] !== 1'b0 || start_a !== 2'b11) begin
      n_fail++;
      $display("FAIL p3_start: start_b[2]=%b expected 0, start_a=%b expected 11", start_b[2], start_a);
    end
    send_key(1'b1, 1'b0, 8'h3D);
    tick(); tick();
    n_checks++;
    if (coin_b[2] !== 1'b0 || coin_a !== 2'b11) begin
      n_fail++;
      $display("FAIL p3_coin: coin_b[2]=%b expected 0, coin_a=%b expected 11", coin_b[2], coin_a);
    end
    send_key(1'b0, 1'b0, 8'h26); tick(); tick();
    send_key(1'b0, 1'b0, 8'h3D); tick(); tick();
    send_key(1'b1, 1'b0, 8'h2D);
    tick(); tick();
    n_checks++;
    if (dir_a[7] !== 1'b0 || dir_b[7] !== 1'b0) begin
      n_fail++; $display("FAIL p2_up: dir_a[7]=%b dir_b[7]=%b expected 0", dir_a[7], dir_b[7]);
    end
    send_key(1'b0, 1'b1, 8'h2D);  // ext-prefixed release must not match
    tick(); tick();
    n_checks++;
    if (dir_a[7] !== 1'b0) begin
      n_fail++; $display("FAIL p2_ext_ignored: dir_a[7]=%b expected 0", dir_a[7]);
    end
    send_key(1'b0, 1'b0, 8'h2D);
    tick(); tick();
    n_checks++;
    if (dir_a[7] !== 1'b1) begin
      n_fail++; $display("FAIL p2_release: dir_a[7]=%b expected 1", dir_a[7]);
    end
  endtask

  task automatic test_reset_mid_pulse();
    joy_a[4] = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (coin_a[0] !== 1'b0) begin
      n_fail++; $display("FAIL midpulse_active: coin_a[0]=%b expected 0", coin_a[0]);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (coin_a[0] !== 1'b1) begin
      n_fail++; $display("FAIL midpulse_async_reset: coin_a[0]=%b expected 1", coin_a[0]);
    end
    repeat (3) tick();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_checks++;
      if (coin_a[0] !== 1'b1) begin
        n_fail++; $display("FAIL held_after_reset cycle %0d: coin_a[0]=%b expected 1", k, coin_a[0]);
      end
    end
    joy_a[4] = 1'b0;
    tick(); tick();
    for (int k = 0; k < 12; k++) begin
      joy_a[4] = 1'b1;
      tick();
      n_checks++;
      if (coin_a[0] !== ((k < PulseA) ? 1'b0 : 1'b1)) begin
        n_fail++;
        $display("FAIL fresh_pulse cycle %0d: coin_a[0]=%b expected %b",
                 k, coin_a[0], (k < PulseA) ? 1'b0 : 1'b1);
      end
    end
    joy_a[4] = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int idx, p, b;
    logic [7:0] code;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, 23);
        code = (idx < 20) ? keymap[idx].code : 8'(8'h1C + idx);
        send_key(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), code);
      end else if ($urandom_range(0, 7) == 0) begin
        ps2_key[9:0] = 10'($urandom);  // data churn without a toggle
      end
      if ($urandom_range(0, 2) == 0) begin
        p = $urandom_range(0, PA - 1); b = $urandom_range(0, 5);
        joy_a[16*p+b] = ~joy_a[16*p+b];
      end
      if ($urandom_range(0, 2) == 0) begin
        p = $urandom_range(0, PB - 1); b = $urandom_range(0, 5);
        joy_b[16*p+b] = ~joy_b[16*p+b];
      end
      if ($urandom_range(0, 9) == 0) begin
        p = $urandom_range(0, PA - 1);
        joy_a[16*p+6 +: 10] = 10'($urandom);
      end
      if ($urandom_range(0, 15) == 0) swap = ~swap;
      tick();
      n_checks++;
      if (dir_a !== e_dir[0][4*PA-1:0]) begin
        n_fail++; $display("FAIL rand_dir_a c%0d: got %b want %b", c, dir_a, e_dir[0][4*PA-1:0]);
      end
      n_checks++;
      if (coin_a !== e_coin[0][PA-1:0] || start_a !== e_start[0][PA-1:0]) begin
        n_fail++;
        $display("FAIL rand_cs_a c%0d: coin %b/%b start %b/%b (got/want)",
                 c, coin_a, e_coin[0][PA-1:0], start_a, e_start[0][PA-1:0]);
      end
      n_checks++;
      if (dir_b !== e_dir[1]) begin
        n_fail++; $display("FAIL rand_dir_b c%0d: got %b want %b", c, dir_b, e_dir[1]);
      end
      n_checks++;
      if (coin_b !== e_coin[1] || start_b !== e_start[1]) begin
        n_fail++;
        $display("FAIL rand_cs_b c%0d: coin %b/%b start %b/%b (got/want)",
                 c, coin_b, e_coin[1], start_b, e_start[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arrow_ext();
    test_socd();
    test_coin_no_retrigger();
    test_swap();
    test_player_range();
    test_reset_mid_pulse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/arcade_input_mapper.md
# arcade_input_mapper

Generalised player-input front end for arcade cores. It decodes `ps2_key` toggle events into per-player key state and merges that state with up to four `hps_io` joysticks. Coin inputs are stretched to a fixed-length pulse, opposing directions are optionally resolved, and coin/start can be swapped per build. It sits between `hps_io` and the game core and drives the core's active-low control inputs directly.

## Interface

**Parameters**
- `PLAYERS`, default 2: number of players, legal range 1–4.
- `COIN_PULSE`, default 120000: coin output assertion length in clk_sys cycles. 10 ms at 12 MHz. Must be ≥1.
- `SOCD_NEUTRAL`, default 1: when 1, left+right together yields neither, and up+down together yields neither.

**Ports**
- `clk_sys`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ps2_key`  in  11  {toggle, pressed, ext, scancode[7:0]}.
- `joy`  in  16*PLAYERS  player p occupies [16p+15:16p]. Bits: [0] right, [1] left, [2] down, [3] up, [4] coin, [5] start.
- `swap_cs`  in  1  1 = route each player's coin signal to `start_n` and start signal to `coin_n`.
- `dir_n`  out  4*PLAYERS  active-low, per player {up, down, left, right}.
- `coin_n`  out  PLAYERS  active-low stretched coin.
- `start_n`  out  PLAYERS  active-low start.

## Operation

**Key decode**
- A key event occurs when `ps2_key[10]` differs from its registered copy.
- The first clock after reset deasserts only primes the copy; no decode happens on that clock.
- On an event, the matched key state is set to `ps2_key[9]`.
- Arrow keys match on scancode only and ignore ext: 75 up, 72 down, 6B left, 74 right → P1.
- All other keys require ext=0:
  - P2 directions: 2D up, 2B down, 23 left, 34 right (only when PLAYERS ≥ 2).
  - Starts P1..P4: 16, 1E, 26, 25.
  - Coins P1..P4: 2E, 36, 3D, 3E.
- Codes for players ≥ PLAYERS are ignored. Unmatched codes change nothing.

**Merge**
- Each raw signal is the OR of the key state and the corresponding joystick bit.

**SOCD**
- With `SOCD_NEUTRAL`=1, a raw left+right pair resolves to neither asserted; raw up+down likewise.
- With `SOCD_NEUTRAL`=0, raw values pass through unchanged.

**Coin stretcher** (one per player)
- A register holds the previous raw coin. A rising edge of raw coin with the counter at 0 loads the counter with COIN_PULSE.
- The coin is active while the counter is nonzero. The counter decrements once per clock.
- Rising edges while the counter is nonzero are ignored; there is no retrigger and no queueing.
- Holding the coin input produces exactly one pulse.

**Start**
- Level signal, no stretching.

**Swap**
- `swap_cs` is applied combinationally ahead of the output registers and may change at any time.

**Outputs**
- All outputs are registered and inverted (active-low).

## Timing

- Reset asserted: all key states cleared; counters, prev-coin and toggle-copy registers cleared; all outputs forced to 1 (inactive) asynchronously.
- Key event: if the toggle is sampled at edge N, the key state updates at edge N; the output changes at edge N+1.
- Joystick bit change sampled at edge N → output changes at edge N. Latency is 1 register.
- Coin: if the rising raw edge is sampled at edge N, `coin_n` is 0 from edge N through edge N+COIN_PULSE-1 and returns to 1 at edge N+COIN_PULSE. That is exactly COIN_PULSE cycles low.
- Reset during a coin pulse: `coin_n` goes to 1 immediately. A coin still held after reset does not produce a pulse until it is released and pressed again. The prev-coin register reloads from raw on the first clock after reset, before edge detection is enabled.
- Simultaneous key event and joystick change on the same signal: the OR applies, so the signal is asserted if either source is asserted.

## Test plan

1. **Reset behaviour.** Assert reset with `ps2_key[10]`=1 and all joy bits 0, then release. Required: all outputs stay 1 for at least 10 cycles; no phantom event.
2. **Arrow key with ext set.** Toggle with {pressed=1, ext=1, 6B}. Required: `dir_n[1]` (P1 left) goes to 0 two edges after the toggle. Release event → returns to 1.
3. **SOCD neutral.** SOCD_NEUTRAL=1. Drive `joy[1]`=1 and `joy[0]`=1 (P1 left+right). Required: P1 left and right both 1. Drop `joy[0]` → left goes to 0 on the next edge.
4. **Coin pulse, no retrigger.** COIN_PULSE=8. Pulse `joy[20]` (P2 coin) high for 3 cycles, then again 2 cycles later. Required: exactly one 8-cycle low on `coin_n[1]`. A third press after the pulse ends produces a second 8-cycle low.
5. **Swap.** `swap_cs`=1, key 16 pressed (P1 start). Required: `coin_n[0]`=0 and `start_n[0]`=1, not stretched. Release → `coin_n[0]`=1.
6. **Reset mid-pulse.** COIN_PULSE=100, held coin, reset asserted at cycle 40 for 3 cycles. Required: `coin_n` goes to 1 asynchronously. No new pulse while the coin stays held. Release then press again → a fresh 100-cycle pulse.
